// File: rtl/mux_alu_src_pipe_if.sv
// Handshake bundle for mux_alu_src_pipe: operand candidates and select on the
// input side, selected operand on the output side, plus the pipeline flush.
interface mux_alu_src_pipe_if #(
    parameter int WIDTH = 32
);
    logic             flush;
    logic [1:0]       sel;
    logic [WIDTH-1:0] data_0;
    logic [WIDTH-1:0] data_2;
    logic [WIDTH-1:0] data_3;
    logic             in_valid;
    logic             in_ready;
    logic [WIDTH-1:0] out_data;
    logic [1:0]       out_sel;
    logic             out_valid;
    logic             out_ready;

    // Upstream/downstream environment side
    modport master (
        output flush, sel, data_0, data_2, data_3, in_valid, out_ready,
        input  in_ready, out_data, out_sel, out_valid
    );

    // Operand-select pipeline side
    modport slave (
        input  flush, sel, data_0, data_2, data_3, in_valid, out_ready,
        output in_ready, out_data, out_sel, out_valid
    );
endinterface

// File: rtl/mux_alu_src_pipe.sv
// ALU source-operand mux followed by a 2-entry skid buffer. The operand is
// chosen at input transfer; only the chosen value and its select are stored.
module mux_alu_src_pipe #(
    parameter int          WIDTH     = 32,
    parameter int unsigned CONST_VAL = 4
) (
    input logic             clk,
    input logic             reset,
    mux_alu_src_pipe_if.slave bus
);

    // Constant operand, zero-extended or truncated to the data width
    localparam logic [WIDTH-1:0] CONST_OP = WIDTH'(CONST_VAL);

    typedef enum logic [1:0] {
        EMPTY = 2'd0,
        ONE   = 2'd1,
        FULL  = 2'd2
    } state_t;

    function automatic logic [WIDTH-1:0] select_operand(
        input logic [1:0]       s,
        input logic [WIDTH-1:0] d0,
        input logic [WIDTH-1:0] d2,
        input logic [WIDTH-1:0] d3
    );
        logic [WIDTH-1:0] r;
        case (s)
            2'b11:   r = CONST_OP;
            2'b10:   r = d0;
            2'b01:   r = d2;
            default: r = d3;
        endcase
        return r;
    endfunction

    state_t           state;
    state_t           state_next;
    logic             in_ready_q;
    logic [WIDTH-1:0] main_data_p0;
    logic [1:0]       main_sel_p0;
    logic [WIDTH-1:0] skid_data_p1;
    logic [1:0]       skid_sel_p1;
    logic [WIDTH-1:0] sel_value;
    logic             out_valid;
    logic             in_fire;
    logic             out_fire;
    logic             load_main_new;
    logic             load_skid;
    logic             move_skid;

    assign sel_value = select_operand(bus.sel, bus.data_0, bus.data_2, bus.data_3);
    assign out_valid = (state != EMPTY);
    assign in_fire   = bus.in_valid & in_ready_q;
    assign out_fire  = out_valid & bus.out_ready;

    // Next-state and register-load decisions for the skid buffer
    always_comb begin
        state_next    = state;
        load_main_new = 1'b0;
        load_skid     = 1'b0;
        move_skid     = 1'b0;
        if (bus.flush) begin
            state_next = EMPTY;
        end else begin
            case (state)
                EMPTY: begin
                    if (in_fire) begin
                        state_next    = ONE;
                        load_main_new = 1'b1;
                    end
                end
                ONE: begin
                    if (in_fire && out_fire) begin
                        load_main_new = 1'b1;
                    end else if (in_fire) begin
                        state_next = FULL;
                        load_skid  = 1'b1;
                    end else if (out_fire) begin
                        state_next = EMPTY;
                    end
                end
                FULL: begin
                    // in_ready is low here, so no input can arrive
                    if (out_fire) begin
                        state_next = ONE;
                        move_skid  = 1'b1;
                    end
                end
                default: state_next = EMPTY;
            endcase
        end
    end

    // State register; in_ready is registered from the next state so it has
    // no combinational path from any input
    always_ff @(posedge clk) begin
        if (!reset) begin
            state      <= EMPTY;
            in_ready_q <= 1'b1;
        end else begin
            state      <= state_next;
            in_ready_q <= (state_next != FULL);
        end
    end

    // Main (head) and skid entry registers
    always_ff @(posedge clk) begin
        if (!reset) begin
            main_data_p0 <= '0;
            main_sel_p0  <= 2'b00;
            skid_data_p1 <= '0;
            skid_sel_p1  <= 2'b00;
        end else begin
            if (load_main_new) begin
                main_data_p0 <= sel_value;
                main_sel_p0  <= bus.sel;
            end else if (move_skid) begin
                main_data_p0 <= skid_data_p1;
                main_sel_p0  <= skid_sel_p1;
            end
            if (load_skid) begin
                skid_data_p1 <= sel_value;
                skid_sel_p1  <= bus.sel;
            end
        end
    end

    // Stale head contents are hidden whenever nothing is valid
    assign bus.in_ready  = in_ready_q;
    assign bus.out_valid = out_valid;
    assign bus.out_data  = out_valid ? main_data_p0 : '0;
    assign bus.out_sel   = out_valid ? main_sel_p0 : 2'b00;

endmodule

// File: tb/tb_mux_alu_src_pipe.sv
// Scoreboard bench for mux_alu_src_pipe: the driver pushes hand-computed
// expected entries, a negedge monitor pops and compares on output transfers.
module tb_mux_alu_src_pipe;

    logic clk;
    logic reset;
    int   checks;
    int   errors;
    logic [33:0] q[$];
    logic [31:0] stream_tab[8];

    mux_alu_src_pipe_if #(.WIDTH(32)) bus ();
    mux_alu_src_pipe_if #(.WIDTH(8))  bus8 ();

    mux_alu_src_pipe #(.WIDTH(32), .CONST_VAL(4)) dut (
        .clk  (clk),
        .reset(reset),
        .bus  (bus)
    );

    mux_alu_src_pipe #(.WIDTH(8), .CONST_VAL(260)) dut8 (
        .clk  (clk),
        .reset(reset),
        .bus  (bus8)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    task automatic chk(input string name, input logic [33:0] act, input logic [33:0] exp);
        checks++;
        if (act !== exp) begin
            errors++;
            $display("FAIL %s: got %0h expected %0h", name, act, exp);
        end
    endtask

    // Monitor: compare every output transfer against the scoreboard head
    initial begin
        logic        hold_prev;
        logic [33:0] prev;
        logic [33:0] e;
        hold_prev = 1'b0;
        prev      = '0;
        forever begin
            @(negedge clk);
            if (reset === 1'b1) begin
                if (bus.out_valid === 1'b1) begin
                    if (hold_prev)
                        chk("hold_stable", {bus.out_sel, bus.out_data}, prev);
                    if (bus.out_ready === 1'b1) begin
                        if (q.size() == 0) begin
                            checks++;
                            errors++;
                            $display("FAIL unexpected_out: got %0h expected no output",
                                     {bus.out_sel, bus.out_data});
                        end else begin
                            e = q.pop_front();
                            chk("out", {bus.out_sel, bus.out_data}, e);
                        end
                    end
                end else begin
                    chk("idle_zero", {bus.out_sel, bus.out_data}, 34'd0);
                end
                hold_prev = bus.out_valid && !bus.out_ready && !bus.flush;
                prev      = {bus.out_sel, bus.out_data};
            end else begin
                hold_prev = 1'b0;
            end
        end
    end

    // Watchdog
    initial begin
        #200000;
        $display("FAIL watchdog: got timeout expected finish");
        $fatal(1, "timeout");
    end

    task automatic send(input logic [1:0] s, input logic [31:0] d0, input logic [31:0] exp,
                        input bit acc, input bit lat);
        bus.sel      = s;
        bus.data_0   = d0;
        bus.in_valid = 1'b1;
        @(negedge clk);
        chk("in_ready", 34'(bus.in_ready), 34'(acc));
        if (acc) q.push_back({s, exp});
        @(posedge clk);
        #1;
        bus.in_valid = 1'b0;
        if (lat) begin
            chk("lat_valid", 34'(bus.out_valid), 34'd1);
            chk("lat_data", {bus.out_sel, bus.out_data}, {s, exp});
        end
    endtask

    task automatic do_flush(input logic [1:0] s);
        bus.flush    = 1'b1;
        bus.sel      = s;
        bus.in_valid = 1'b1;
        @(posedge clk);
        #1;
        bus.flush    = 1'b0;
        bus.in_valid = 1'b0;
        q.delete();
        chk("flush_valid", 34'(bus.out_valid), 34'd0);
        chk("flush_ready", 34'(bus.in_ready), 34'd1);
    endtask

    task automatic drain();
        int n;
        n = 0;
        while (q.size() != 0 && n < 50) begin
            @(posedge clk);
            n++;
        end
        #1;
        chk("drain_left", 34'(q.size()), 34'd0);
        chk("drain_idle", 34'(bus.out_valid), 34'd0);
    endtask

    task automatic idle(input int n);
        repeat (n) @(posedge clk);
        #1;
    endtask

    initial begin
        checks = 0;
        errors = 0;
        stream_tab[0] = 32'h0000_0001; stream_tab[1] = 32'h8000_0000;
        stream_tab[2] = 32'hFFFF_FFFF; stream_tab[3] = 32'h1234_5678;
        stream_tab[4] = 32'h0000_0000; stream_tab[5] = 32'hDEAD_BEEF;
        stream_tab[6] = 32'h7FFF_FFFF; stream_tab[7] = 32'h0F0F_0F0F;

        reset         = 1'b0;
        bus.flush     = 1'b0;
        bus.sel       = 2'b00;
        bus.data_0    = 32'hA0A0_A0A0;
        bus.data_2    = 32'h2222_2222;
        bus.data_3    = 32'h3333_3333;
        bus.in_valid  = 1'b0;
        bus.out_ready = 1'b1;
        bus8.flush     = 1'b0;
        bus8.sel       = 2'b11;
        bus8.data_0    = 8'hAA;
        bus8.data_2    = 8'h22;
        bus8.data_3    = 8'h33;
        bus8.in_valid  = 1'b1;
        bus8.out_ready = 1'b1;

        // Reset state
        idle(2);
        chk("rst_valid", 34'(bus.out_valid), 34'd0);
        chk("rst_ready", 34'(bus.in_ready), 34'd1);
        chk("rst_out", {bus.out_sel, bus.out_data}, 34'd0);
        reset = 1'b1;

        // Constant select right after reset, then each data select
        send(2'b11, 32'hA0A0_A0A0, 32'h0000_0004, 1'b1, 1'b1);
        send(2'b10, 32'hA0A0_A0A0, 32'hA0A0_A0A0, 1'b1, 1'b1);
        send(2'b01, 32'hA0A0_A0A0, 32'h2222_2222, 1'b1, 1'b1);
        send(2'b00, 32'hA0A0_A0A0, 32'h3333_3333, 1'b1, 1'b1);
        drain();

        // Narrow build: 260 truncated to 8 bits
        chk("const_w8", {25'd0, bus8.out_valid, bus8.out_data}, {25'd0, 1'b1, 8'h04});

        // Backpressure: third input refused
        bus.out_ready = 1'b0;
        send(2'b01, 32'hA0A0_A0A0, 32'h2222_2222, 1'b1, 1'b0);
        send(2'b00, 32'hA0A0_A0A0, 32'h3333_3333, 1'b1, 1'b0);
        send(2'b10, 32'hA0A0_A0A0, 32'hA0A0_A0A0, 1'b0, 1'b0);
        idle(2);
        bus.out_ready = 1'b1;
        drain();

        // Full-rate streaming
        for (int i = 0; i < 8; i++)
            send(2'b10, stream_tab[i], stream_tab[i], 1'b1, 1'b1);
        drain();
        bus.data_0 = 32'hA0A0_A0A0;

        // Flush while FULL with a concurrent (refused) input
        bus.out_ready = 1'b0;
        send(2'b11, 32'hA0A0_A0A0, 32'h0000_0004, 1'b1, 1'b0);
        send(2'b10, 32'hA0A0_A0A0, 32'hA0A0_A0A0, 1'b1, 1'b0);
        do_flush(2'b00);
        bus.out_ready = 1'b1;
        idle(3);

        // Flush in ONE: head leaves as completed, concurrent input discarded
        send(2'b00, 32'hA0A0_A0A0, 32'h3333_3333, 1'b1, 1'b0);
        do_flush(2'b01);
        idle(3);
        chk("after_flush_left", 34'(q.size()), 34'd0);

        // Reset mid-operation while FULL beats flush and handshakes
        bus.out_ready = 1'b0;
        send(2'b01, 32'hA0A0_A0A0, 32'h2222_2222, 1'b1, 1'b0);
        send(2'b00, 32'hA0A0_A0A0, 32'h3333_3333, 1'b1, 1'b0);
        reset        = 1'b0;
        bus.flush    = 1'b1;
        bus.in_valid = 1'b1;
        bus.sel      = 2'b10;
        @(posedge clk);
        #1;
        reset        = 1'b1;
        bus.flush    = 1'b0;
        bus.in_valid = 1'b0;
        q.delete();
        chk("mrst_valid", 34'(bus.out_valid), 34'd0);
        chk("mrst_out", {bus.out_sel, bus.out_data}, 34'd0);
        chk("mrst_ready", 34'(bus.in_ready), 34'd1);

        // Recovery after reset
        bus.out_ready = 1'b1;
        send(2'b11, 32'hA0A0_A0A0, 32'h0000_0004, 1'b1, 1'b1);
        drain();
        idle(2);

        $display("Simulation finished: %0d checks, %0d errors", checks, errors);
        $finish;
    end

endmodule

// File: doc/mux_alu_src_pipe.md
MUX_ALU_SRC_PIPE -- requirements
Module: mux_alu_src_pipe

Interface
REQ-001 SHALL have parameter WIDTH, default 32: data width of every data port.
REQ-002 SHALL have parameter CONST_VAL, default 4: constant operand, truncated to WIDTH bits.
REQ-003 SHALL use one clock; reset is synchronous and active-low.
REQ-004 Port: clk  in  1  rising-edge clock for all state.
REQ-005 Port: reset  in  1  synchronous, active-low reset, sampled on rising clk.
REQ-006 Port: flush  in  1  synchronous pipeline clear, active-high.
REQ-007 Port: sel  in  2  source select: 11 = CONST_VAL, 10 = data_0, 01 = data_2, 00 = data_3.
REQ-008 Port: data_0 / data_2 / data_3  in  WIDTH each  candidate operands.
REQ-009 Port: in_valid  in  1  upstream offers sel and data this cycle.
REQ-010 Port: in_ready  out  1  block can accept; driven from a register only.
REQ-011 Port: out_data  out  WIDTH  selected operand at buffer head.
REQ-012 Port: out_sel  out  2  sel value that produced out_data.
REQ-013 Port: out_valid  out  1  out_data/out_sel are valid.
REQ-014 Port: out_ready  in  1  downstream accepts this cycle.

Function
REQ-015 Input transfer SHALL occur on a rising edge with in_valid=1 and in_ready=1; output transfer SHALL occur with out_valid=1 and out_ready=1.
REQ-016 Selection SHALL be evaluated combinationally at input transfer; only the selected WIDTH-bit value and its sel are stored.
REQ-017 Storage SHALL be a 2-entry skid buffer (main + skid register), FIFO order, no reordering or duplication.
REQ-018 States SHALL be EMPTY (0 entries), ONE (1), FULL (2); out_valid=1 in ONE and FULL, in_ready=0 only in FULL.
REQ-019 Transitions: EMPTY + in -> ONE; ONE + in only -> FULL; ONE + out only -> EMPTY; ONE + in + out -> ONE (new entry at head); FULL + out -> ONE (skid entry moves to head); all other cases hold.
REQ-020 Latency SHALL be 1 cycle: data accepted at edge N is on out_data with out_valid=1 after edge N when buffer was EMPTY.
REQ-021 Full-rate throughput SHALL be sustained: with out_ready held 1, one transfer per cycle in and out, state stays ONE.
REQ-022 in_valid while in_ready=0 SHALL be ignored; no entry is written or overwritten.
REQ-023 out_data and out_sel SHALL stay stable while out_valid=1 and out_ready=0.
REQ-024 When out_valid=0, out_data SHALL be 0 and out_sel SHALL be 00.
REQ-025 flush=1 SHALL force EMPTY at the next edge, discarding stored entries; a simultaneous input transfer is discarded; a simultaneous output transfer counts as completed.
REQ-026 Width rule: CONST_VAL SHALL be zero-extended or truncated to WIDTH; data is never sign-extended or altered.

Reset
REQ-027 reset=0 at a rising edge SHALL force EMPTY, out_valid=0, in_ready=1, out_data=0, out_sel=00, both registers cleared.
REQ-028 reset SHALL take priority over flush and any handshake in the same cycle, including mid-operation with buffer FULL.
REQ-029 First input transfer SHALL be possible on the first edge after reset returns to 1.

Verification
REQ-030 After reset, sel=11, in_valid=1, out_ready=1 -> next cycle out_data=0x00000004, out_sel=11, out_valid=1.
REQ-031 Each sel: data_0=0xA0A0A0A0, data_2=0x22222222, data_3=0x33333333; sel 10/01/00 -> out_data A0A0A0A0 / 22222222 / 33333333 in order.
REQ-032 Backpressure: out_ready=0, send 3 inputs (sel 01,00,10) -> in_ready=0 after 2nd; 3rd ignored; release out_ready -> outputs 22222222 then 33333333 only.
REQ-033 Streaming: out_ready=1, 8 back-to-back inputs -> 8 outputs on consecutive cycles, 1-cycle latency, in_ready stays 1.
REQ-034 flush while FULL with in_valid=1 -> next cycle out_valid=0, in_ready=1, flushed and concurrent inputs never appear.
REQ-035 reset=0 while FULL and out_ready=0 -> next cycle out_valid=0, out_data=0, in_ready=1; WIDTH=8, CONST_VAL=260 build yields constant 0x04.
